// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART TX byte interface between NUM_REQ byte-stream requesters.
// Ownership is granted round-robin per packet. The owner keeps the
// transmitter until it delivers a byte marked last. With HDR_EN=1 an ID
// header byte (ID_BASE | owner index) goes out ahead of every packet.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_data/   per-requester byte stream; requester i uses
//   req_last/req_ready    bit i and req_data[8i+7:8i]
//   tx_valid/tx_data/     byte stream towards the UART TX shifter
//   tx_ready
//   grant                 one-hot current owner, 0 while idle
//   busy                  high while a header or packet is in flight
module uart_tx_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter int         HDR_EN  = 1,
    parameter logic [7:0] ID_BASE = 8'hF0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    // Arbitration leads straight into the packet when no header is wanted.
    localparam logic [1:0] ST_AFTER_ARB = (HDR_EN != 0) ? ST_HDR : ST_DATA;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;

    logic               win_found_s;
    logic [IW-1:0]      win_idx_s;
    logic               own_valid_s;
    logic               own_last_s;
    logic [7:0]         own_data_s;
    logic               own_xfer_s;

    // Round-robin search: first valid requester after the pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        // Wrapped candidates (index <= pointer) have the lowest priority;
        // scanning downward leaves the smallest such index as the pick.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IW'(i) <= ptr_q)) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'(i);
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
        // Candidates above the pointer override any wrapped pick.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IW'(i) > ptr_q)) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'(i);
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Owner's stream, selected by the registered grant index.
    assign own_valid_s = req_valid[gidx_q];
    assign own_last_s  = req_last[gidx_q];
    assign own_data_s  = req_data[{gidx_q, 3'b000} +: 8];
    assign own_xfer_s  = (state_q == ST_DATA) && own_valid_s && tx_ready;

    // Next-state logic for FSM, grant and round-robin pointer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    gidx_d  = win_idx_s;
                    state_d = ST_AFTER_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (tx_ready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (own_xfer_s && own_last_s) begin
                    ptr_d   = gidx_q;
                    grant_d = {NUM_REQ{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State registers; reset leaves the pointer on the last requester so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= {NUM_REQ{1'b0}};
            gidx_q  <= {IW{1'b0}};
            ptr_q   <= IW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output decode. tx_valid comes from state and the owner's valid only,
    // never from tx_ready; the owner's req_ready follows tx_ready in DATA.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = {NUM_REQ{1'b0}};
        case (state_q)
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = ID_BASE | 8'(gidx_q);
            end
            ST_DATA: begin
                tx_valid  = own_valid_s;
                tx_data   = own_data_s;
                req_ready = grant_q & {NUM_REQ{tx_ready}};
            end
            default: begin
                tx_valid  = 1'b0;
                tx_data   = 8'h00;
                req_ready = {NUM_REQ{1'b0}};
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q == ST_HDR) || (state_q == ST_DATA);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run checked against a packet-level reference model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        tx_valid, tx_ready, busy;
    logic [7:0]  tx_data;

    // Second instance without headers.
    logic [3:0]  rv2, rl2, rr2, g2;
    logic [31:0] rd2;
    logic        tv2, tr2, b2;
    logic [7:0]  td2;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1), .ID_BASE(8'hF0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(0), .ID_BASE(8'hF0)) dut_nohdr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv2), .req_data(rd2), .req_last(rl2),
        .req_ready(rr2),
        .tx_valid(tv2), .tx_data(td2), .tx_ready(tr2),
        .grant(g2), .busy(b2)
    );

    int checks = 0;
    int errors = 0;

    // Byte sources: {last, data} per entry.
    logic [8:0] src_mem [4][32];
    int         src_hd [4];
    int         src_tl [4];
    bit         hold [4];

    // Observed tx stream (handshaken bytes).
    logic [7:0] stm [64];
    int         ns;

    // Per-cycle observation and the inputs that were driven for it.
    logic       obs_tv, obs_busy;
    logic [7:0] obs_td;
    logic [3:0] obs_g, obs_rr;
    logic [3:0] in_v, in_l;
    logic [7:0] in_front [4];
    logic       in_tr;

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_tl[r]] = {l, d};
        src_tl[r]++;
    endtask

    function automatic bit drained();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) if (src_hd[i] != src_tl[i]) e = 1'b0;
        return e;
    endfunction

    // One clock cycle: drive sources, sample at negedge, retire accepted bytes.
    task automatic tick();
        logic [3:0] acc;
        logic [8:0] f;
        for (int i = 0; i < 4; i++) begin
            f = 9'h000;
            if (src_hd[i] < src_tl[i]) f = src_mem[i][src_hd[i]];
            req_valid[i] = (src_hd[i] < src_tl[i]) && !hold[i];
            req_data[8*i +: 8] = req_valid[i] ? f[7:0] : 8'($urandom);
            req_last[i] = req_valid[i] ? f[8] : 1'($urandom);
            in_front[i] = f[7:0];
        end
        in_v  = req_valid;
        in_l  = req_last;
        in_tr = tx_ready;
        @(negedge clk);
        obs_tv   = tx_valid;
        obs_td   = tx_data;
        obs_g    = grant;
        obs_rr   = req_ready;
        obs_busy = busy;
        if (tx_valid && tx_ready && ns < 64) begin
            stm[ns] = tx_data;
            ns++;
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) src_hd[i]++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_hd[i] = 0;
            src_tl[i] = 0;
            hold[i]   = 1'b0;
        end
        req_valid = 4'h0;
        req_last  = 4'h0;
        req_data  = 32'h0;
        tx_ready  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ns = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 32'hA5A5A5A5;
        tx_ready  = 1'b1;
        rv2 = 4'hF; rl2 = 4'hF; rd2 = 32'h5A5A5A5A; tr2 = 1'b1;
        #1 rst_n = 1'b0;
        #7;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx: tx_valid=%b tx_data=%h expected 0/00", tx_valid, tx_data);
        end
        checks++;
        if (grant !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant_busy: grant=%b busy=%b expected 0000/0", grant, busy);
        end
        checks++;
        if (req_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if (tv2 !== 1'b0 || g2 !== 4'h0 || b2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_nohdr: tv=%b grant=%b busy=%b expected 0", tv2, g2, b2);
        end
        rv2 = 4'h0; rl2 = 4'h0; rd2 = 32'h0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_s [3];
        int gcnt;
        exp_s = '{8'hF0, 8'h41, 8'h42};
        do_reset();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b1);
        gcnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (obs_g == 4'b0001) gcnt++;
        end
        checks++;
        if (ns !== 3) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes expected 3", ns);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stm[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, stm[i], exp_s[i]);
            end
        end
        checks++;
        if (gcnt !== 3) begin
            errors++;
            $display("FAIL basic_grant_cycles: got %0d expected 3", gcnt);
        end
        checks++;
        if (obs_g !== 4'h0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end_idle: grant=%b busy=%b expected 0000/0", obs_g, obs_busy);
        end
    endtask

    task automatic test_rr();
        logic [7:0] exp_s [10];
        logic       eb;
        exp_s = '{8'hF0, 8'h10, 8'hF1, 8'h11, 8'hF2, 8'h12, 8'hF3, 8'h13, 8'hF0, 8'h20};
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
        push(0, 8'h20, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            eb = (k % 3 != 0) && (k < 15);
            checks++;
            if (obs_busy !== eb) begin
                errors++;
                $display("FAIL rr_busy_c%0d: got %b expected %b", k, obs_busy, eb);
            end
            if (k % 3 == 1) begin
                checks++;
                if (obs_g !== (4'b0001 << ((k / 3) % 4))) begin
                    errors++;
                    $display("FAIL rr_grant_c%0d: got %b expected %b", k, obs_g,
                             4'b0001 << ((k / 3) % 4));
                end
            end
        end
        checks++;
        if (ns !== 10) begin
            errors++;
            $display("FAIL rr_count: got %0d bytes expected 10", ns);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (stm[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL rr_byte%0d: got %h expected %h", i, stm[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       rdy [7];
        logic [7:0] exp_s [3];
        rdy   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_s = '{8'hF1, 8'h55, 8'hAA};
        ns = 0;
        push(1, 8'h55, 1'b0);
        push(1, 8'hAA, 1'b1);
        for (int k = 0; k < 7; k++) begin
            tx_ready = rdy[k];
            tick();
            if (k == 1) begin
                checks++;
                if ({obs_tv, obs_td} !== {1'b1, 8'hF1}) begin
                    errors++;
                    $display("FAIL bp_header: valid=%b data=%h expected 1/F1", obs_tv, obs_td);
                end
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if ({obs_tv, obs_td} !== {1'b1, 8'h55}) begin
                    errors++;
                    $display("FAIL bp_hold_c%0d: valid=%b data=%h expected 1/55", k, obs_tv, obs_td);
                end
                checks++;
                if (obs_rr !== (rdy[k] ? 4'b0010 : 4'b0000)) begin
                    errors++;
                    $display("FAIL bp_ready_c%0d: got %b expected %b", k, obs_rr,
                             rdy[k] ? 4'b0010 : 4'b0000);
                end
            end
            if (k == 6) begin
                checks++;
                if (obs_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_end_idle: busy=%b expected 0", obs_busy);
                end
            end
        end
        tx_ready = 1'b1;
        checks++;
        if (ns !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes expected 3", ns);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stm[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h expected %h", i, stm[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_s [6];
        exp_s = '{8'hF2, 8'h21, 8'h22, 8'h23, 8'hF3, 8'h31};
        ns = 0;
        tx_ready = 1'b1;
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h23, 1'b1);
        push(3, 8'h31, 1'b1);
        for (int k = 0; k < 14; k++) begin
            hold[2] = (k >= 3) && (k <= 7);
            tick();
            if (k >= 3 && k <= 7) begin
                checks++;
                if (obs_tv !== 1'b0 || obs_g !== 4'b0100 || obs_rr[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_c%0d: tx_valid=%b grant=%b ready3=%b expected 0/0100/0",
                             k, obs_tv, obs_g, obs_rr[3]);
                end
            end
            if (k == 11) begin
                checks++;
                if (obs_g !== 4'b1000) begin
                    errors++;
                    $display("FAIL stall_next_grant: got %b expected 1000", obs_g);
                end
            end
        end
        hold[2] = 1'b0;
        checks++;
        if (ns !== 6) begin
            errors++;
            $display("FAIL stall_count: got %0d bytes expected 6", ns);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (stm[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", i, stm[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_nohdr();
        rv2 = 4'b0010;
        rl2 = 4'b0010;
        rd2 = 32'h0000_7E00;
        tr2 = 1'b1;
        @(negedge clk);
        checks++;
        if (g2 !== 4'h0 || tv2 !== 1'b0) begin
            errors++;
            $display("FAIL nohdr_arb: grant=%b tx_valid=%b expected 0000/0", g2, tv2);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (g2 !== 4'b0010 || b2 !== 1'b1 || rr2 !== 4'b0010) begin
            errors++;
            $display("FAIL nohdr_grant: grant=%b busy=%b ready=%b expected 0010/1/0010", g2, b2, rr2);
        end
        checks++;
        if ({tv2, td2} !== {1'b1, 8'h7E}) begin
            errors++;
            $display("FAIL nohdr_data: valid=%b data=%h expected 1/7E", tv2, td2);
        end
        @(posedge clk);
        #1;
        rv2 = 4'h0;
        rl2 = 4'h0;
        @(negedge clk);
        checks++;
        if (g2 !== 4'h0 || b2 !== 1'b0 || tv2 !== 1'b0) begin
            errors++;
            $display("FAIL nohdr_end: grant=%b busy=%b valid=%b expected 0", g2, b2, tv2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_s [3];
        exp_s = '{8'hF0, 8'h02, 8'h03};
        do_reset();
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        push(0, 8'h03, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        req_valid = 4'h0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || grant !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: tx_valid=%b grant=%b busy=%b expected 0", tx_valid, grant, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ns = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) begin
                checks++;
                if (obs_g !== 4'b0001 || {obs_tv, obs_td} !== {1'b1, 8'hF0}) begin
                    errors++;
                    $display("FAIL midrst_regrant: grant=%b valid=%b data=%h expected 0001/1/F0",
                             obs_g, obs_tv, obs_td);
                end
            end
        end
        checks++;
        if (ns !== 3) begin
            errors++;
            $display("FAIL midrst_count: got %0d bytes expected 3", ns);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stm[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL midrst_byte%0d: got %h expected %h", i, stm[i], exp_s[i]);
            end
        end
    endtask

    // Packet-level model: owner (-1 = nobody), whether its header went out,
    // and the round-robin pointer.
    task automatic test_random();
        int         own, ptr, len, c;
        bit         hdr_done, found, done;
        logic       e_tv, e_busy;
        logic [7:0] e_td;
        logic [3:0] e_g, e_rr;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 3; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
            end
        end
        own = -1;
        ptr = 3;
        hdr_done = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            tx_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) hold[i] = ($urandom_range(0, 3) == 0);
            tick();
            if (own < 0) begin
                e_tv = 1'b0; e_td = 8'h00; e_g = 4'h0; e_busy = 1'b0; e_rr = 4'h0;
            end else if (!hdr_done) begin
                e_tv = 1'b1; e_td = 8'hF0 + 8'(own); e_g = 4'b0001 << own;
                e_busy = 1'b1; e_rr = 4'h0;
            end else begin
                e_tv = in_v[own]; e_td = in_front[own]; e_g = 4'b0001 << own;
                e_busy = 1'b1; e_rr = in_tr ? (4'b0001 << own) : 4'h0;
            end
            checks++;
            if (obs_tv !== e_tv || (e_tv && obs_td !== e_td)) begin
                errors++;
                $display("FAIL rand_tx_c%0d: valid=%b data=%h expected %b/%h", cyc, obs_tv, obs_td, e_tv, e_td);
            end
            checks++;
            if (obs_g !== e_g || obs_busy !== e_busy) begin
                errors++;
                $display("FAIL rand_grant_c%0d: grant=%b busy=%b expected %b/%b", cyc, obs_g, obs_busy, e_g, e_busy);
            end
            checks++;
            if (obs_rr !== e_rr) begin
                errors++;
                $display("FAIL rand_ready_c%0d: got %b expected %b", cyc, obs_rr, e_rr);
            end
            if (own < 0) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    c = (ptr + k) % 4;
                    if (!found && in_v[c]) begin
                        found = 1'b1;
                        own = c;
                        hdr_done = 1'b0;
                    end
                end
            end else if (!hdr_done) begin
                if (in_tr) hdr_done = 1'b1;
            end else if (in_v[own] && in_tr && in_l[own]) begin
                ptr = own;
                own = -1;
            end
            if (own < 0 && drained()) done = 1'b1;
        end
        for (int i = 0; i < 4; i++) hold[i] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand_drain: sources not drained within budget, model owner=%0d", own);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        ns = 0;
        for (int i = 0; i < 4; i++) begin
            src_hd[i] = 0;
            src_tl[i] = 0;
            hold[i]   = 1'b0;
        end
        test_reset();
        test_basic();
        test_rr();
        test_backpressure();
        test_stall();
        test_nohdr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter in tt_um_njzhu_uart between NUM_REQ byte-stream requesters. Grants are round-robin at packet granularity: a granted requester keeps the transmitter until it delivers a byte marked last. When HDR_EN=1, an ID header byte is sent before each packet so the host can demultiplex streams. The block sits between on-chip byte sources and the UART TX shifter's valid/ready byte interface.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
HDR_EN, 1, 1 = emit header byte ID_BASE|index before each packet; 0 = no header.
ID_BASE, 8'hF0, header base value; bits [2:0] must be 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  byte from requester i at [8i+7:8i]
req_last  in  NUM_REQ  marks final byte of packet, qualified by req_valid
req_ready  out  NUM_REQ  byte accepted from requester i this cycle
tx_valid  out  1  byte to UART TX valid
tx_data  out  8  byte to UART TX
tx_ready  in  1  UART TX accepts byte
grant  out  NUM_REQ  one-hot current owner; 0 when idle
busy  out  1  high in HDR or DATA

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset (asynchronous, immediate): state=IDLE; grant=0; busy=0; tx_valid=0; tx_data=0; req_ready=0; round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- Transfer on any interface occurs when valid&&ready on a rising clk edge.
- State IDLE: tx_valid=0, req_ready=0.
  - If any req_valid is high, select the first requester with req_valid set, searching from pointer+1 upward with wrap at NUM_REQ.
  - Register the one-hot grant; next state is HDR if HDR_EN=1, else DATA.
  - Arbitration costs exactly 1 cycle; IDLE transfers no bytes.
- State HDR: tx_valid=1; tx_data=ID_BASE|g, where g is the granted index.
  - Hold both stable until tx_ready; on that edge go to DATA.
  - req_ready=0 for all requesters.
- State DATA: combinational pass-through from the owner.
  - tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready; all other req_ready=0.
  - On a handshake with req_last[g]=1: pointer<=g, grant<=0, state<=IDLE.
  - Requester drops valid mid-packet: stall with grant held. There is no timeout, and other requesters wait.
- tx_valid never depends combinationally on tx_ready. req_ready[g] may depend on tx_ready.
- Non-owners' req_valid/req_last are ignored while busy.
- A request that asserts on the same edge a packet ends is not seen until the following IDLE cycle. Minimum gap between packets is 1 idle cycle.
- Single-byte packet (first byte has last=1): HDR then one DATA byte, then IDLE.
- Outside DATA, tx_data=0 in IDLE and header value in HDR.
- grant is stable from the IDLE->HDR/DATA edge until the edge after the last handshake.
- busy=1 in HDR and DATA.
- Reset asserted mid-packet aborts the packet immediately; the partial packet is not resumed.

Test Plan:
1. Reset, then req0 sends bytes 0x41,0x42(last) with tx_ready=1 -> tx stream F0,41,42; grant=0001 for 3 cycles, then 0; busy low after.
2. All four requesters hold valid, each sending a 1-byte packet 0x10+i (last) -> header/data order F0,10,F1,11,F2,12,F3,13, then F0 again; one idle cycle between packets.
3. tx_ready toggled 1,0,0,1 during req1 packet (0x55,0xAA last) -> tx_valid/tx_data held stable while ready=0; req_ready[1] high only in ready cycles; no byte duplicated or lost.
4. req2 mid-packet drops valid for 5 cycles while req3 is valid -> tx_valid=0 during the gap, grant stays 0100, req_ready[3]=0; packet resumes and completes before req3 is granted.
5. HDR_EN=0, req1 sends 0x7E(last) -> tx stream 7E only; IDLE->DATA in 1 cycle.
6. rst_n pulled low after the header is accepted during req0 packet -> tx_valid, grant and busy are 0 the same cycle; after release, req0 is granted again first, with header F0.
